// File: rtl/sha512_pkg.sv
// ============================================================================
// Module      : sha512_pkg
// Description : Shared types and constants for the SHA-512 compression
//               controller, datapath and wordConst wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha512_pkg;

  localparam int NUM_ROUNDS = 80;
  localparam int MSG_WORDS  = 16;
  localparam int ROUND_W    = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  // True while W_t still comes straight from the message stream.
  function automatic logic is_msg_round(input logic [ROUND_W-1:0] t);
    return t < ROUND_W'(MSG_WORDS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha512_round_ctrl.sv
// ============================================================================
// Module      : sha512_round_ctrl
// Description : Block-level control FSM for the SHA-512 compression datapath:
//               message-word handshake, round index and register strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha512_round_ctrl
  import sha512_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               first_block,
  input  logic               last_block,
  output logic               ready,
  input  logic               msg_valid,
  output logic               msg_ready,
  output logic [ROUND_W-1:0] round,
  output logic               w_sel,
  output logic               w_shift,
  output logic               hash_init,
  output logic               ab_init,
  output logic               ab_update,
  output logic               hash_accum,
  output logic               digest_valid,
  input  logic               digest_ack
);

  localparam logic [ROUND_W-1:0] c_LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  state_t             r_state;
  logic [ROUND_W-1:0] r_round;
  logic               r_first;
  logic               r_last;

  logic w_in_round;
  logic w_msg_phase;
  logic w_advance;

  assign w_in_round  = (r_state == ROUND);
  assign w_msg_phase = is_msg_round(r_round);
  // During message rounds a missing word stalls the round; afterwards W comes
  // from the schedule and every cycle advances.
  assign w_advance   = w_in_round && (!w_msg_phase || msg_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_round <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_first <= first_block;
            r_last  <= last_block;
            r_state <= INIT;
          end
        end
        INIT: begin
          r_round <= '0;
          r_state <= ROUND;
        end
        ROUND: begin
          if (w_advance) begin
            if (r_round == c_LAST_ROUND) begin
              r_round <= '0;
              r_state <= FINAL;
            end else begin
              r_round <= r_round + ROUND_W'(1);
            end
          end
        end
        FINAL: begin
          r_state <= r_last ? DONE : IDLE;
        end
        DONE: begin
          if (digest_ack) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_round <= '0;
        end
      endcase
    end
  end

  assign ready        = (r_state == IDLE);
  assign ab_init      = (r_state == INIT);
  // The datapath gives hash_init priority, so a..h pick up the IV this edge.
  assign hash_init    = (r_state == INIT) && r_first;
  assign round        = r_round;
  assign msg_ready    = w_in_round && w_msg_phase;
  assign w_sel        = w_in_round && !w_msg_phase;
  assign ab_update    = w_advance;
  assign w_shift      = w_advance;
  assign hash_accum   = (r_state == FINAL);
  assign digest_valid = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_sha512_round_ctrl.sv
// ============================================================================
// Module      : tb_sha512_round_ctrl
// Description : Directed, table-driven bench for sha512_round_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha512_round_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       first_block = 1'b0;
  logic       last_block = 1'b0;
  logic       msg_valid = 1'b0;
  logic       digest_ack = 1'b0;
  logic       ready, msg_ready, w_sel, w_shift, hash_init, ab_init;
  logic       ab_update, hash_accum, digest_valid;
  logic [6:0] round;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sha512_round_ctrl u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .first_block  (first_block),
    .last_block   (last_block),
    .ready        (ready),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .round        (round),
    .w_sel        (w_sel),
    .w_shift      (w_shift),
    .hash_init    (hash_init),
    .ab_init      (ab_init),
    .ab_update    (ab_update),
    .hash_accum   (hash_accum),
    .digest_valid (digest_valid),
    .digest_ack   (digest_ack)
  );

  // {ready, round, w_sel, w_shift, msg_ready, hash_init, ab_init, ab_update, hash_accum, digest_valid}
  logic [15:0] w_obs;
  assign w_obs = {ready, round, w_sel, w_shift, msg_ready, hash_init, ab_init,
                  ab_update, hash_accum, digest_valid};

  function automatic logic [15:0] pk(input logic rdy, input logic [6:0] rnd,
                                     input logic ws, input logic wsh, input logic mr,
                                     input logic hi, input logic ai, input logic au,
                                     input logic ha, input logic dv);
    return {rdy, rnd, ws, wsh, mr, hi, ai, au, ha, dv};
  endfunction

  localparam logic [15:0] c_IDLE = 16'h8000;

  // Expected outputs in cycle cyc after the accepting edge, for a block with a
  // stall of len cycles starting at round 5 (cycles 7..6+len).
  function automatic logic [15:0] exp_at(input int cyc, input logic first,
                                         input logic last, input int len);
    int   t;
    logic stall;
    if (cyc == 1) return pk(0, 7'd0, 0, 0, 0, first, 1, 0, 0, 0);
    if (cyc <= 81 + len) begin
      stall = (cyc >= 7) && (cyc < 7 + len);
      if (cyc < 7)    t = cyc - 2;
      else if (stall) t = 5;
      else            t = cyc - 2 - len;
      return pk(0, 7'(t), t >= 16, !stall, t < 16, 0, 0, !stall, 0, 0);
    end
    if (cyc == 82 + len) return pk(0, 7'd0, 0, 0, 0, 0, 0, 0, 1, 0);
    if (cyc == 83 + len && last) return pk(0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    return c_IDLE;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one block already accepted on the previous edge; on its last cycle
  // it optionally hands the next start request to the controller.
  task automatic run_block(input string tag, input logic first, input logic last,
                           input int len, input logic nstart, input logic nfirst,
                           input logic nlast);
    for (int cyc = 1; cyc <= 83 + len; cyc++) begin
      tick();
      start       = 1'b0;
      first_block = 1'b0;
      last_block  = 1'b0;
      digest_ack  = 1'b0;
      msg_valid   = !((cyc >= 7) && (cyc < 7 + len));
      if (cyc == 83 + len) begin
        if (last) digest_ack = 1'b1;
        else begin
          start       = nstart;
          first_block = nfirst;
          last_block  = nlast;
        end
      end
      #1;
      check($sformatf("%s_c%0d", tag, cyc), 32'(w_obs), 32'(exp_at(cyc, first, last, len)));
    end
    if (last) begin
      tick();
      digest_ack  = 1'b0;
      start       = nstart;
      first_block = nfirst;
      last_block  = nlast;
      #1;
      check($sformatf("%s_idle", tag), 32'(w_obs), 32'(c_IDLE));
    end
  endtask

  typedef struct {
    int          cyc;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int idx;
    int n_upd;
    int n_acc;

    tbl[0] = '{1,  pk(0, 7'd0,  0, 0, 0, 1, 1, 0, 0, 0)};
    tbl[1] = '{2,  pk(0, 7'd0,  0, 1, 1, 0, 0, 1, 0, 0)};
    tbl[2] = '{7,  pk(0, 7'd5,  0, 1, 1, 0, 0, 1, 0, 0)};
    tbl[3] = '{17, pk(0, 7'd15, 0, 1, 1, 0, 0, 1, 0, 0)};
    tbl[4] = '{18, pk(0, 7'd16, 1, 1, 0, 0, 0, 1, 0, 0)};
    tbl[5] = '{50, pk(0, 7'd48, 1, 1, 0, 0, 0, 1, 0, 0)};
    tbl[6] = '{81, pk(0, 7'd79, 1, 1, 0, 0, 0, 1, 0, 0)};
    tbl[7] = '{82, pk(0, 7'd0,  0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[8] = '{83, pk(0, 7'd0,  0, 0, 0, 0, 0, 0, 0, 1)};

    // Reset, then a quiet idle period.
    repeat (3) tick();
    reset = 1'b0;
    tick();
    #1;
    check("reset_state", 32'(w_obs), 32'(c_IDLE));
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      check($sformatf("idle_%0d", i), 32'(w_obs), 32'(c_IDLE));
    end

    // Single block, no stalls; msg_valid toggles after round 16 and start is
    // raised mid-block and in DONE, both of which must be ignored.
    start = 1'b1; first_block = 1'b1; last_block = 1'b1; msg_valid = 1'b1;
    idx   = 0;
    n_upd = 0;
    for (int cyc = 1; cyc <= 83; cyc++) begin
      tick();
      first_block = 1'b0;
      last_block  = 1'b0;
      start       = (cyc == 30) || (cyc == 83);
      msg_valid   = (cyc < 18) ? 1'b1 : cyc[0];
      #1;
      if (ab_update) n_upd++;
      if (idx < 9 && tbl[idx].cyc == cyc) begin
        check($sformatf("tbl_c%0d", cyc), 32'(w_obs), 32'(tbl[idx].exp));
        idx++;
      end
    end
    check("ab_update_count", 32'(n_upd), 32'd80);
    tick();
    start      = 1'b0;
    digest_ack = 1'b1;
    #1;
    check("done_holds", 32'(w_obs), 32'(pk(0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 1)));
    tick();
    digest_ack = 1'b0;
    #1;
    check("ack_to_idle", 32'(w_obs), 32'(c_IDLE));

    // Three-cycle stall at round 5; ack in the first DONE cycle.
    start = 1'b1; first_block = 1'b1; last_block = 1'b1;
    run_block("stall", 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b0);

    // Two back-to-back blocks: second start in the cycle ready returns.
    run_block("blk1", 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    run_block("blk2", 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);

    // Reset asserted while the block sits in round 40.
    start = 1'b1; first_block = 1'b1; last_block = 1'b1; msg_valid = 1'b1;
    n_acc = 0;
    for (int cyc = 1; cyc <= 42; cyc++) begin
      tick();
      start = 1'b0; first_block = 1'b0; last_block = 1'b0;
      if (cyc == 42) reset = 1'b1;
      #1;
      if (hash_accum) n_acc++;
      check($sformatf("rst_c%0d", cyc), 32'(w_obs), 32'(exp_at(cyc, 1'b1, 1'b1, 0)));
    end
    tick();
    reset = 1'b0;
    #1;
    if (hash_accum) n_acc++;
    check("abort_idle", 32'(w_obs), 32'(c_IDLE));
    check("abort_no_accum", 32'(n_acc), 32'd0);
    start = 1'b1; first_block = 1'b1; last_block = 1'b1;
    run_block("post_rst", 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
